memory_handshake: RTL and testbench

- Single-port synchronous SRAM model with a valid/ready handshake front door.
- Backdoor access: the storage array is a plain reg array, so benches load and dump it hierarchically with $readmemh and $writememb.
- Used as the target memory for front-door and backdoor access verification.

---
 rtl/memory_handshake.sv | 74 +++++++
 tb/tb_memory_handshake.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/memory_handshake.sv
// Purpose: single-port synchronous SRAM model behind a valid/ready request port.
// Latency: write completes at the accepting edge; read data is registered one cycle after the request.
// Backpressure: ready_o is low only during reset and up to the first edge after release, then it stays high.
//
// Ports:
//   clk_i    - clock, all state changes on the rising edge (except reset)
//   rst_i    - asynchronous active-low reset
//   addr_i   - word address
//   wdata_i  - write data
//   rdata_o  - registered read data, holds its value between reads
//   wr_rd_i  - 1 = write, 0 = read
//   valid_i  - request valid
//   ready_o  - registered, memory can accept a request this cycle
module memory_handshake #(
   parameter int WIDTH      = 16,
   parameter int DEPTH      = 1024,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [WIDTH-1:0]      wdata_i,
   output logic [WIDTH-1:0]      rdata_o,
   input  logic                  wr_rd_i,
   input  logic                  valid_i,
   output logic                  ready_o
);

   // One extra bit so DEPTH == 2**ADDR_WIDTH is still representable.
   localparam logic [ADDR_WIDTH:0] DEPTH_W = DEPTH[ADDR_WIDTH:0];

   // Storage stays a plain unpacked reg array named mem so benches can reach it
   // hierarchically. It is deliberately not reset: contents survive reset.
   reg [WIDTH-1:0] mem [0:DEPTH-1];

   logic ready_q;
   logic [WIDTH-1:0] rdata_q;
   logic xfer;
   logic in_range;

   // ready_q is low at the edge that follows reset release, so requests are
   // never accepted while in reset or on that first edge.
   assign xfer     = valid_i & ready_q;
   assign in_range = ({1'b0, addr_i} < DEPTH_W);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ready_q <= 1'b0;
      end else begin
         ready_q <= 1'b1;
      end
   end

   // Out-of-range reads return zero rather than aliasing onto a valid word.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         rdata_q <= '0;
      end else if (xfer && !wr_rd_i) begin
         rdata_q <= in_range ? mem[addr_i] : '0;
      end
   end

   // Array write kept in its own unreset process so backdoor writers may also
   // deposit into mem; the ready_q gate blocks writes during reset.
   always @(posedge clk_i) begin
      if (xfer && wr_rd_i && in_range) begin
         mem[addr_i] <= wdata_i;
      end
   end

   assign ready_o = ready_q;
   assign rdata_o = rdata_q;

endmodule

// File: tb/tb_memory_handshake.sv
module tb_memory_handshake;

   logic        clk_i;
   logic        rst_i;
   logic [9:0]  addr_i;
   logic [15:0] wdata_i;
   logic [15:0] rdata_o;
   logic        wr_rd_i;
   logic        valid_i;
   logic        ready_o;

   int n_checks;
   int n_fail;

   memory_handshake #(
      .WIDTH      (16),
      .DEPTH      (1024),
      .ADDR_WIDTH (10)
   ) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .addr_i  (addr_i),
      .wdata_i (wdata_i),
      .rdata_o (rdata_o),
      .wr_rd_i (wr_rd_i),
      .valid_i (valid_i),
      .ready_o (ready_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   function automatic logic [15:0] pat(input int i);
      return 16'((i * 257) + 7);
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge and settle 1 ns after it.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic fd_write(input logic [9:0] a, input logic [15:0] d);
      valid_i = 1'b1;
      wr_rd_i = 1'b1;
      addr_i  = a;
      wdata_i = d;
      tick();
   endtask

   task automatic fd_read(input logic [9:0] a);
      valid_i = 1'b1;
      wr_rd_i = 1'b0;
      addr_i  = a;
      tick();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      valid_i  = 1'b0;
      wr_rd_i  = 1'b0;
      addr_i   = '0;
      wdata_i  = '0;
      rst_i    = 1'b1;

      // Reset: falling edge at 1 ns, held low through 21 ns.
      #1 rst_i = 1'b0;
      #2;
      check("reset_ready", {15'd0, ready_o}, 16'd0);
      check("reset_rdata", rdata_o, 16'h0000);
      #18 rst_i = 1'b1;                       // t = 21
      #1;
      check("release_ready_before_edge", {15'd0, ready_o}, 16'd0);
      tick();                                 // edge at 25
      check("ready_after_first_edge", {15'd0, ready_o}, 16'd1);

      // Front-door write stream over the full address range.
      for (int i = 0; i < 1024; i++) fd_write(10'(i), pat(i));
      check("rdata_unchanged_by_writes", rdata_o, 16'h0000);

      // Front-door read stream, one request per cycle.
      for (int i = 0; i < 1024; i++) begin
         fd_read(10'(i));
         check($sformatf("read_stream_%0d", i), rdata_o, pat(i));
      end

      // Write 0xA5A5 at 3, read it straight back.
      fd_write(10'd3, 16'hA5A5);
      fd_read(10'd3);
      check("read_a5a5_addr3", rdata_o, 16'hA5A5);

      // Front-door write, backdoor read.
      fd_write(10'd0, 16'h1234);
      fd_write(10'd1023, 16'hFFFF);
      valid_i = 1'b0;
      tick();
      check("backdoor_read_addr0", dut.mem[0], 16'b0001001000110100);
      check("backdoor_read_addr1023", dut.mem[1023], 16'b1111111111111111);

      // Backdoor write, front-door read.
      dut.mem[5]    = 16'hBEEF;
      dut.mem[1023] = 16'h0001;
      fd_read(10'd5);
      check("frontdoor_read_beef", rdata_o, 16'hBEEF);
      fd_read(10'd1023);
      check("frontdoor_read_0001", rdata_o, 16'h0001);

      // Hold: read 7, drop valid while other fields wiggle.
      fd_write(10'd7, 16'h0077);
      fd_read(10'd7);
      check("read_addr7", rdata_o, 16'h0077);
      valid_i = 1'b0;
      wr_rd_i = 1'b0;
      addr_i  = 10'd5;
      tick();
      check("hold_idle_read_fields", rdata_o, 16'h0077);
      wr_rd_i = 1'b1;
      addr_i  = 10'd7;
      wdata_i = 16'hDEAD;
      tick();
      check("hold_idle_write_fields", rdata_o, 16'h0077);

      // Mid-stream reset while a read is being presented.
      fd_read(10'd5);
      check("read_before_reset", rdata_o, 16'hBEEF);
      #2 rst_i = 1'b0;                        // mid-cycle
      #1;
      check("midreset_rdata_async", rdata_o, 16'h0000);
      check("midreset_ready_async", {15'd0, ready_o}, 16'd0);
      // A write presented during reset must be dropped.
      wr_rd_i = 1'b1;
      addr_i  = 10'd7;
      wdata_i = 16'hDEAD;
      tick();
      check("midreset_ready_held", {15'd0, ready_o}, 16'd0);
      #2 rst_i = 1'b1;                        // mid-cycle release
      // Read presented on the first edge after release is dropped.
      wr_rd_i = 1'b0;
      addr_i  = 10'd7;
      tick();
      check("post_release_ready", {15'd0, ready_o}, 16'd1);
      check("post_release_first_req_dropped", rdata_o, 16'h0000);
      fd_read(10'd7);
      check("retained_addr7", rdata_o, 16'h0077);

      // Back-to-back read-after-write, then a write leaves rdata alone.
      fd_write(10'd9, 16'h00AA);
      fd_read(10'd9);
      check("raw_addr9", rdata_o, 16'h00AA);
      fd_write(10'd10, 16'h5555);
      check("write_keeps_rdata", rdata_o, 16'h00AA);
      fd_read(10'd10);
      check("read_addr10", rdata_o, 16'h5555);
      valid_i = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
